// File: rtl/wave_event_capture.sv
// wave_event_capture: dual-channel signal-present interval capture.
// Each channel measures start timestamp, length and peak |PD - midscale| of
// every HAVE-high interval, parks the closed event in a one-deep pending slot,
// and a round-robin arbiter feeds a single registered valid/ready output.
//
// Ports:
//   CLK_P, RESET_N            clock, async active-low reset
//   PD_A/PD_B, HAVE_A/HAVE_B  offset-binary samples and signal-present flags
//   EVT_VALID/EVT_READY       output handshake
//   EVT_CH/PEAK/LEN/TS/TRUNC  event record (channel, peak, length, start ts, truncated)
//   DROP_CNT                  saturating count of events lost to a full pending slot
module wave_event_capture #(
  parameter int unsigned MIN_LEN = 4,
  parameter int unsigned MAX_LEN = 4095
) (
  input  logic        CLK_P,
  input  logic        RESET_N,
  input  logic [13:0] PD_A,
  input  logic [13:0] PD_B,
  input  logic        HAVE_A,
  input  logic        HAVE_B,
  output logic        EVT_VALID,
  input  logic        EVT_READY,
  output logic        EVT_CH,
  output logic [13:0] EVT_PEAK,
  output logic [11:0] EVT_LEN,
  output logic [31:0] EVT_TS,
  output logic        EVT_TRUNC,
  output logic [7:0]  DROP_CNT
);

  localparam int unsigned PD_W   = 14;
  localparam int unsigned LEN_W  = 12;
  localparam int unsigned TS_W   = 32;
  localparam int unsigned DROP_W = 8;
  localparam int unsigned NCH    = 2;

  localparam logic [PD_W-1:0]   MIDSCALE  = PD_W'(8192);
  localparam logic [LEN_W-1:0]  MAX_LEN_C = LEN_W'(MAX_LEN);
  localparam logic [DROP_W-1:0] DROP_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_WAIT_LOW = 2'd2
  } state_e;

  typedef struct packed {
    logic             ch;
    logic [PD_W-1:0]  peak;
    logic [LEN_W-1:0] len;
    logic [TS_W-1:0]  ts;
    logic             trunc;
  } evt_t;

  // Unsigned distance from midscale; PD = 0 yields the maximum 8192.
  function automatic logic [PD_W-1:0] mag_of(input logic [PD_W-1:0] pd);
    return (pd >= MIDSCALE) ? (pd - MIDSCALE) : (MIDSCALE - pd);
  endfunction

  logic [TS_W-1:0]   ts_q;
  state_e            state_q    [NCH];
  state_e            state_d    [NCH];
  evt_t              acc_q      [NCH];
  evt_t              acc_d      [NCH];
  evt_t              close_rec  [NCH];
  logic              close_c    [NCH];
  logic              keep_c     [NCH];
  logic              have       [NCH];
  logic [PD_W-1:0]   mag        [NCH];
  logic              pend_vld_q [NCH];
  logic              pend_vld_d [NCH];
  evt_t              pend_q     [NCH];
  evt_t              pend_d     [NCH];
  logic              grant      [NCH];
  logic              drop_c     [NCH];
  logic              out_vld_q, out_vld_d;
  evt_t              out_q, out_d;
  logic              rr_q, rr_d;
  logic              out_free, both_pend;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [DROP_W:0]   drop_sum;

  assign have[0] = HAVE_A;
  assign have[1] = HAVE_B;
  assign mag[0]  = mag_of(PD_A);
  assign mag[1]  = mag_of(PD_B);

  // Free-running timestamp.
  always_ff @(posedge CLK_P or negedge RESET_N) begin
    if (!RESET_N) ts_q <= '0;
    else          ts_q <= ts_q + TS_W'(1);
  end

  // Per-channel interval FSM: next state, accumulator update and close detection.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      state_d[c]   = state_q[c];
      acc_d[c]     = acc_q[c];
      close_rec[c] = acc_q[c];
      close_c[c]   = 1'b0;
      keep_c[c]    = 1'b0;
      case (state_q[c])
        ST_IDLE: begin
          if (have[c]) begin
            state_d[c]     = ST_RUN;
            acc_d[c].ch    = 1'(c);
            acc_d[c].ts    = ts_q;
            acc_d[c].len   = LEN_W'(1);
            acc_d[c].peak  = mag[c];
            acc_d[c].trunc = 1'b0;
          end
        end
        ST_RUN: begin
          // A sample arriving at MAX_LEN closes the event without being counted.
          if (!have[c] || (acc_q[c].len == MAX_LEN_C)) begin
            close_c[c]         = 1'b1;
            close_rec[c].trunc = have[c];
            state_d[c]         = have[c] ? ST_WAIT_LOW : ST_IDLE;
          end else begin
            acc_d[c].len = acc_q[c].len + LEN_W'(1);
            if (mag[c] > acc_q[c].peak) acc_d[c].peak = mag[c];
          end
        end
        ST_WAIT_LOW: begin
          if (!have[c]) state_d[c] = ST_IDLE;
        end
        default: state_d[c] = ST_IDLE;
      endcase
      keep_c[c] = close_c[c] && (32'(close_rec[c].len) >= MIN_LEN);
    end
  end

  // Arbitration, output register load, pending slot refill and drop counting.
  always_comb begin
    out_free  = !out_vld_q || EVT_READY;
    both_pend = pend_vld_q[0] && pend_vld_q[1];
    grant[0]  = out_free && pend_vld_q[0] && (!pend_vld_q[1] || !rr_q);
    grant[1]  = out_free && pend_vld_q[1] && (!pend_vld_q[0] ||  rr_q);
    rr_d      = (out_free && both_pend) ? !rr_q : rr_q;

    out_vld_d = out_vld_q && !EVT_READY;
    out_d     = out_q;
    if (grant[0]) begin
      out_vld_d = 1'b1;
      out_d     = pend_q[0];
    end else if (grant[1]) begin
      out_vld_d = 1'b1;
      out_d     = pend_q[1];
    end

    for (int c = 0; c < NCH; c++) begin
      // A slot granted this cycle counts as empty for a same-cycle close.
      pend_vld_d[c] = pend_vld_q[c] && !grant[c];
      pend_d[c]     = pend_q[c];
      drop_c[c]     = 1'b0;
      if (keep_c[c]) begin
        if (!pend_vld_d[c]) begin
          pend_vld_d[c] = 1'b1;
          pend_d[c]     = close_rec[c];
        end else begin
          drop_c[c] = 1'b1;
        end
      end
    end

    drop_sum = {1'b0, drop_q} + (DROP_W+1)'(drop_c[0]) + (DROP_W+1)'(drop_c[1]);
    drop_d   = (drop_sum > (DROP_W+1)'(DROP_MAX)) ? DROP_MAX : drop_sum[DROP_W-1:0];
  end

  // State registers.
  always_ff @(posedge CLK_P or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int c = 0; c < NCH; c++) begin
        state_q[c]    <= ST_IDLE;
        acc_q[c]      <= '0;
        pend_vld_q[c] <= 1'b0;
        pend_q[c]     <= '0;
      end
      out_vld_q <= 1'b0;
      out_q     <= '0;
      rr_q      <= 1'b0;
      drop_q    <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        state_q[c]    <= state_d[c];
        acc_q[c]      <= acc_d[c];
        pend_vld_q[c] <= pend_vld_d[c];
        pend_q[c]     <= pend_d[c];
      end
      out_vld_q <= out_vld_d;
      out_q     <= out_d;
      rr_q      <= rr_d;
      drop_q    <= drop_d;
    end
  end

  assign EVT_VALID = out_vld_q;
  assign EVT_CH    = out_q.ch;
  assign EVT_PEAK  = out_q.peak;
  assign EVT_LEN   = out_q.len;
  assign EVT_TS    = out_q.ts;
  assign EVT_TRUNC = out_q.trunc;
  assign DROP_CNT  = drop_q;

endmodule
